// File: rtl/pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Owns the architectural PC. Fetches one word at a time from instruction
// memory over a req/ready + rvalid handshake, then holds the fetched word
// for the core until it is accepted with instr_ready. On acceptance the next
// PC is chosen from PC+4, PCTarget or ALUResult (bit0 cleared). A misaligned
// target parks the sequencer in a sticky trap state that only rst_n leaves.
//
// Optional feature: define FETCH_COUNT_EN to add the fetch_count output,
// which counts successful (non-trapping) advances.
//
// Ports:
//   clk, rst_n              rising-edge clock, async active-low reset
//   PCSrc                   next-PC select, sampled only on advance
//   PCTarget, ALUResult     branch/jal target and jalr target
//   instr_ready             core accepts the held instruction
//   imem_req, imem_addr     fetch request and address (equals PC)
//   imem_ready              memory accepts the request
//   imem_rvalid, imem_rdata read data return
//   instr_valid, Instr      held instruction and its valid flag
//   PC, PCPlus4             address of Instr and that address + 4
//   misalign_trap, trap_addr sticky trap flag and the rejected target
//   fetch_count             (FETCH_COUNT_EN only) successful advance count
// -----------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        PCSrc,
    input  logic [ADDR_W-1:0] PCTarget,
    input  logic [ADDR_W-1:0] ALUResult,
    input  logic              instr_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       Instr,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] PCPlus4,
    output logic              misalign_trap,
    output logic [ADDR_W-1:0] trap_addr
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(3'd4);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RESP = 3'd2,
        ST_HOLD = 3'd3,
        ST_TRAP = 3'd4
    } state_t;

    state_t            state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_plus4_r;
    logic [31:0]       instr_r;
    logic              imem_req_r;
    logic              instr_valid_r;
    logic              misalign_trap_r;
    logic [ADDR_W-1:0] trap_addr_r;
`ifdef FETCH_COUNT_EN
    logic [31:0]       fetch_count_r;
`endif

    logic [ADDR_W-1:0] next_pc_s;
    logic              misalign_s;

    // Candidate next PC for the advance cycle; PC+4 for 00 and 11.
    function automatic logic [ADDR_W-1:0] select_next_pc(
        input logic [1:0]        src,
        input logic [ADDR_W-1:0] seq_pc,
        input logic [ADDR_W-1:0] tgt,
        input logic [ADDR_W-1:0] alu
    );
        logic [ADDR_W-1:0] res;
        case (src)
            2'b01:   res = tgt;
            2'b10:   res = {alu[ADDR_W-1:1], 1'b0};
            default: res = seq_pc;
        endcase
        return res;
    endfunction

    // Misalignment of the selected target; jalr has bit0 cleared so only
    // bit1 can make it misaligned, and the sequential path never can.
    function automatic logic target_misaligned(
        input logic [1:0]        src,
        input logic [ADDR_W-1:0] tgt,
        input logic [ADDR_W-1:0] alu
    );
        logic res;
        case (src)
            2'b01:   res = (tgt[1:0] != 2'b00);
            2'b10:   res = alu[1];
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Next-PC selection and alignment check, consumed only on advance.
    always_comb begin
        next_pc_s  = select_next_pc(PCSrc, pc_plus4_r, PCTarget, ALUResult);
        misalign_s = target_misaligned(PCSrc, PCTarget, ALUResult);
    end

    // Fetch FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            pc_r            <= RESET_PC;
            pc_plus4_r      <= RESET_PC + PC_STEP;
            instr_r         <= 32'h0000_0000;
            imem_req_r      <= 1'b0;
            instr_valid_r   <= 1'b0;
            misalign_trap_r <= 1'b0;
            trap_addr_r     <= {ADDR_W{1'b0}};
`ifdef FETCH_COUNT_EN
            fetch_count_r   <= 32'h0000_0000;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r    <= ST_REQ;
                    imem_req_r <= 1'b1;
                end
                ST_REQ: begin
                    // Request stays asserted with a stable address until taken.
                    if (imem_req_r && imem_ready) begin
                        state_r    <= ST_RESP;
                        imem_req_r <= 1'b0;
                    end else begin
                        imem_req_r <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (imem_rvalid) begin
                        instr_r       <= imem_rdata;
                        instr_valid_r <= 1'b1;
                        state_r       <= ST_HOLD;
                    end else begin
                        instr_valid_r <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        instr_valid_r <= 1'b0;
                        if (misalign_s) begin
                            // Trap wins over the PC update; PC keeps its value.
                            misalign_trap_r <= 1'b1;
                            trap_addr_r     <= next_pc_s;
                            state_r         <= ST_TRAP;
                        end else begin
                            pc_r       <= next_pc_s;
                            pc_plus4_r <= next_pc_s + PC_STEP;
                            imem_req_r <= 1'b1;
                            state_r    <= ST_REQ;
`ifdef FETCH_COUNT_EN
                            fetch_count_r <= fetch_count_r + 32'd1;
`endif
                        end
                    end else begin
                        instr_valid_r <= 1'b1;
                    end
                end
                ST_TRAP: begin
                    // Terminal until rst_n.
                    imem_req_r      <= 1'b0;
                    instr_valid_r   <= 1'b0;
                    misalign_trap_r <= 1'b1;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    imem_req_r    <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req      = imem_req_r;
    assign imem_addr     = pc_r;
    assign instr_valid   = instr_valid_r;
    assign Instr         = instr_r;
    assign PC            = pc_r;
    assign PCPlus4       = pc_plus4_r;
    assign misalign_trap = misalign_trap_r;
    assign trap_addr     = trap_addr_r;
`ifdef FETCH_COUNT_EN
    assign fetch_count   = fetch_count_r;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Directed bench for pc_fetch_sequencer. Inputs are driven and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  PCSrc;
    logic [31:0] PCTarget;
    logic [31:0] ALUResult;
    logic        instr_ready;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        misalign_trap;
    logic [31:0] trap_addr;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    pc_fetch_sequencer #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .PCSrc         (PCSrc),
        .PCTarget      (PCTarget),
        .ALUResult     (ALUResult),
        .instr_ready   (instr_ready),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .Instr         (Instr),
        .PC            (PC),
        .PCPlus4       (PCPlus4),
        .misalign_trap (misalign_trap),
        .trap_addr     (trap_addr)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Serve one fetch: wait for imem_req (bounded), accept it, return data
    // in the following cycle. Ends on the falling edge with the DUT in HOLD.
    task automatic serve(input logic [31:0] data);
        int n;
        n = 0;
        imem_ready = 1'b1;
        while (imem_req !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("serve_req_seen", {31'd0, imem_req}, 32'd1);
        @(negedge clk);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hA5A5_A5A5;
    endtask

    // Present instr_ready for one cycle with the given next-PC selection,
    // then scramble the selection inputs so stray sampling would be visible.
    task automatic advance(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
        PCSrc       = src;
        PCTarget    = tgt;
        ALUResult   = alu;
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
        PCSrc       = 2'b01;
        PCTarget    = 32'h0000_0101;
        ALUResult   = 32'h0000_0103;
    endtask

    initial begin
        rst_n       = 1'b0;
        PCSrc       = 2'b00;
        PCTarget    = 32'h0000_0000;
        ALUResult   = 32'h0000_0000;
        instr_ready = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0000_0000;

        // ---- reset values
        repeat (2) @(negedge clk);
        check("rst_pc",        PC,                       32'h0000_0000);
        check("rst_pcplus4",   PCPlus4,                  32'h0000_0004);
        check("rst_instr",     Instr,                    32'h0000_0000);
        check("rst_req",       {31'd0, imem_req},        32'd0);
        check("rst_valid",     {31'd0, instr_valid},     32'd0);
        check("rst_trap",      {31'd0, misalign_trap},   32'd0);
        check("rst_trap_addr", trap_addr,                32'h0000_0000);

        // ---- first fetch latency: valid three rising edges after release
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        @(negedge clk);                       // edge 1: IDLE -> REQ
        check("lat_req",   {31'd0, imem_req}, 32'd1);
        check("lat_addr",  imem_addr,         32'h0000_0000);
        @(negedge clk);                       // edge 2: accepted -> RESP
        check("lat_req_dropped", {31'd0, imem_req}, 32'd0);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0013;
        @(negedge clk);                       // edge 3: data -> HOLD
        imem_rvalid = 1'b0;
        check("lat_valid",   {31'd0, instr_valid}, 32'd1);
        check("lat_instr",   Instr,                32'h0000_0013);
        check("lat_pc",      PC,                   32'h0000_0000);
        check("lat_pcplus4", PCPlus4,              32'h0000_0004);

        // ---- hold stable while instr_ready is low
        repeat (2) @(negedge clk);
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_instr", Instr,                32'h0000_0013);

        // ---- branch to 0x30, then PCTarget 0x40
        advance(2'b01, 32'h0000_0030, 32'h0000_0000);
        check("br30_addr",  imem_addr,            32'h0000_0030);
        check("br30_valid", {31'd0, instr_valid}, 32'd0);
        serve(32'h0000_1111);
        check("br30_pc",    PC,                   32'h0000_0030);
        advance(2'b01, 32'h0000_0040, 32'h0000_0000);
        check("br40_addr",  imem_addr,            32'h0000_0040);
        check("br40_trap",  {31'd0, misalign_trap}, 32'd0);
        serve(32'h0000_2222);
        check("br40_pc",      PC,      32'h0000_0040);
        check("br40_pcplus4", PCPlus4, 32'h0000_0044);
        check("br40_instr",   Instr,   32'h0000_2222);

        // ---- jalr with bit0 set is cleared, bit1 set traps
        advance(2'b10, 32'h0000_0000, 32'h0000_0081);
        check("jalr81_addr", imem_addr,              32'h0000_0080);
        check("jalr81_trap", {31'd0, misalign_trap}, 32'd0);
        serve(32'h0000_3333);
        advance(2'b10, 32'h0000_0000, 32'h0000_0082);
        check("jalr82_trap",      {31'd0, misalign_trap}, 32'd1);
        check("jalr82_trap_addr", trap_addr,              32'h0000_0082);
        check("jalr82_pc",        PC,                     32'h0000_0080);
        check("jalr82_req",       {31'd0, imem_req},      32'd0);
        check("jalr82_valid",     {31'd0, instr_valid},   32'd0);
        // Trap is sticky regardless of memory / core activity.
        imem_ready  = 1'b1;
        instr_ready = 1'b1;
        PCSrc       = 2'b00;
        repeat (3) @(negedge clk);
        check("trap_sticky",  {31'd0, misalign_trap}, 32'd1);
        check("trap_req_low", {31'd0, imem_req},      32'd0);
        check("trap_pc",      PC,                     32'h0000_0080);
        imem_ready  = 1'b0;
        instr_ready = 1'b0;

        // ---- reset clears trap; REQ stall with imem_ready low
        rst_n = 1'b0;
        @(negedge clk);
        check("rst2_trap", {31'd0, misalign_trap}, 32'd0);
        check("rst2_pc",   PC,                     32'h0000_0000);
        rst_n = 1'b1;
        @(negedge clk);                       // now in REQ, not accepted
        imem_rvalid = 1'b1;                   // must be ignored outside RESP
        imem_rdata  = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_req",   {31'd0, imem_req},    32'd1);
            check("stall_addr",  imem_addr,            32'h0000_0000);
            check("stall_instr", Instr,                32'h0000_0000);
            check("stall_pc",    PC,                   32'h0000_0000);
        end
        imem_rvalid = 1'b0;
        serve(32'h0000_4444);
        check("stall_done_instr", Instr, 32'h0000_4444);

        // ---- wrap from 0xFFFF_FFFC
        advance(2'b01, 32'hFFFF_FFFC, 32'h0000_0000);
        serve(32'h0000_5555);
        check("wrap_pc_top",      PC,      32'hFFFF_FFFC);
        check("wrap_pcplus4_top", PCPlus4, 32'h0000_0000);
        advance(2'b00, 32'h0000_0000, 32'h0000_0000);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        serve(32'h0000_6666);
        check("wrap_pc",      PC,                     32'h0000_0000);
        check("wrap_pcplus4", PCPlus4,                32'h0000_0004);
        check("wrap_trap",    {31'd0, misalign_trap}, 32'd0);
        advance(2'b11, 32'h0000_0000, 32'h0000_0000);
        serve(32'h0000_7777);
        check("seq11_pc", PC, 32'h0000_0004);
        advance(2'b00, 32'h0000_0000, 32'h0000_0000);
        serve(32'h0000_8888);
        check("seq00_pc", PC, 32'h0000_0008);
`ifdef FETCH_COUNT_EN
        check("fetch_count_4", fetch_count, 32'd4);
`endif

        // ---- reset during RESP with a stale response after release
        advance(2'b00, 32'h0000_0000, 32'h0000_0000);
        imem_ready = 1'b1;
        @(negedge clk);                       // accepted -> RESP
        check("resp_req_low", {31'd0, imem_req}, 32'd0);
        check("resp_addr",    imem_addr,         32'h0000_000C);
        imem_ready = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("async_rst_pc",    PC,                   32'h0000_0000);
        check("async_rst_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);                       // IDLE -> REQ
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("stale_pc",    PC,                   32'h0000_0000);
        check("stale_valid", {31'd0, instr_valid}, 32'd0);
        check("stale_instr", Instr,                32'h0000_0000);
        check("stale_req",   {31'd0, imem_req},    32'd1);
`ifdef FETCH_COUNT_EN
        check("fetch_count_rst", fetch_count, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
- Consumer side of the branch-target path: takes PCTarget (PC + immediate) and ALUResult (jalr) and owns the architectural PC register.
- Issues word fetches to instruction memory over a req/ready plus rvalid handshake.
- Presents each fetched instruction to the core with a valid/ready handshake.
- Sits between the immediate-target adder / ALU and the instruction memory in the RISC-V datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- ADDR_W, 32, width of PC and all address ports.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- PCSrc  input  2  next-PC select, sampled only on advance: 00 = PC+4, 01 = PCTarget, 10 = ALUResult with bit0 cleared, 11 = PC+4
- PCTarget  input  ADDR_W  branch/jal target from the immediate adder
- ALUResult  input  ADDR_W  jalr target
- instr_ready  input  1  core accepts the current instruction (advance)
- imem_req  output  1  fetch request
- imem_addr  output  ADDR_W  fetch address (equals PC)
- imem_ready  input  1  memory accepts the request
- imem_rvalid  input  1  read data valid
- imem_rdata  input  32  read data
- instr_valid  output  1  Instr, PC and PCPlus4 are valid
- Instr  output  32  held instruction word
- PC  output  ADDR_W  address of Instr
- PCPlus4  output  ADDR_W  PC+4, modulo 2^ADDR_W
- misalign_trap  output  1  sticky misaligned-target flag
- trap_addr  output  ADDR_W  offending target address

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC; Instr=0, trap_addr=0.
  - imem_req=0, instr_valid=0, misalign_trap=0.
  - State=IDLE.
- States:
  - IDLE -> REQ after exactly one cycle.
  - REQ: imem_req=1, imem_addr=PC. Handshake occurs when imem_req and imem_ready are both 1 on a clock edge; then -> RESP. imem_req stays high until accepted.
  - RESP: imem_req=0. On imem_rvalid=1: Instr<=imem_rdata, instr_valid<=1 next cycle, -> HOLD.
  - HOLD: Instr, PC and PCPlus4 stay stable while instr_ready=0. On instr_ready=1 (advance):
    - Compute next PC from PCSrc.
    - If the next PC is aligned: PC<=next, instr_valid<=0, -> REQ.
    - If misaligned: -> TRAP.
  - TRAP: misalign_trap=1, trap_addr=the rejected target, PC holds its old value, imem_req=0, instr_valid=0. Exit only via rst_n.
- Latency:
  - IDLE, then one REQ cycle with imem_ready=1.
  - With imem_rvalid in the cycle after acceptance, instr_valid rises 3 cycles after reset release.
  - Back-to-back steady state: 3 cycles per instruction (REQ, RESP, HOLD).
- Alignment rules:
  - PCSrc=01: misaligned if PCTarget[1:0]!=0.
  - PCSrc=10: bit0 is cleared first; misaligned if ALUResult[1]=1.
  - PC+4 is never misaligned.
- Arithmetic: PCPlus4 and the sequential next PC wrap, so 32'hFFFF_FFFC -> 32'h0000_0000 with no trap.
- PCSrc, PCTarget and ALUResult are ignored outside the advance cycle.
- imem_rvalid outside RESP is ignored.
- imem_rdata is captured only in RESP.
- instr_ready outside HOLD is ignored.
- Reset mid-operation (any state): immediate return to reset values. An outstanding memory response arriving after reset release is ignored, because the FSM is in IDLE/REQ.
- Simultaneous instr_ready and a misaligned target: the trap wins, and PC is not updated.

Optional Feature:
- Macro FETCH_COUNT_EN.
- When defined:
  - Adds output fetch_count[31:0], cleared on reset.
  - Increments by 1 on every successful HOLD advance, wrapping at 2^32.
  - Does not increment on a trapping advance.
- When undefined: no port and no counter logic. All other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0, then release; memory returns 32'h0000_0013 -> imem_addr=0; instr_valid=1 with PC=0 and PCPlus4=4 three cycles after release.
- PC=0x30, PCSrc=01, PCTarget=0x40, instr_ready=1 -> next imem_addr=0x40; misalign_trap stays 0.
- PCSrc=10 with ALUResult=0x81 -> next PC=0x80. Then PCSrc=10 with ALUResult=0x82 -> TRAP: misalign_trap=1, trap_addr=0x82, PC unchanged, imem_req stays 0.
- imem_ready held low for 5 cycles in REQ -> imem_req and imem_addr stable throughout; Instr and PC outputs do not change.
- PC=0xFFFF_FFFC, PCSrc=00, advance -> PC=0, PCPlus4=4, no trap. With FETCH_COUNT_EN defined, 4 advances -> fetch_count=4.
- Assert rst_n=0 during RESP, and drive imem_rvalid=1 one cycle after release -> PC=RESET_PC, instr_valid=0, the stale data is not captured.
